// File: rtl/mctp_sink_pkg.sv
// rtl/mctp_sink_pkg.sv - shared constants and state types for the MCTP write sink
// Contents: fragment type codes, TLP header bit positions, AXI BRESP codes,
// accepted AWSIZE/AWBURST values, bus and assembly FSM state enums.
package mctp_sink_pkg;

    localparam logic [1:0] FRAG_M  = 2'b00;
    localparam logic [1:0] FRAG_L  = 2'b01;
    localparam logic [1:0] FRAG_S  = 2'b10;
    localparam logic [1:0] FRAG_SG = 2'b11;

    localparam int HDR_TYPE_MSB = 127;
    localparam int HDR_TYPE_LSB = 126;
    localparam int HDR_SEQ_MSB  = 125;
    localparam int HDR_SEQ_LSB  = 124;
    localparam int HDR_TAG_MSB  = 123;
    localparam int HDR_TAG_LSB  = 120;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    localparam logic [2:0] AWSIZE_32B   = 3'd5;
    localparam logic [1:0] AWBURST_INCR = 2'b01;

    typedef enum logic [1:0] {B_IDLE, B_DATA, B_RESP} bus_state_t;
    typedef enum logic {A_IDLE, A_ASM} asm_state_t;

endpackage

// File: rtl/mctp_frag_tracker.sv
// rtl/mctp_frag_tracker.sv - MCTP fragment assembly FSM with order checking
// Ports: clk, rst (async active-high); hdr_hs commits the decision for the
// header presented on frag_type/frag_seq/frag_tag. Outputs are combinational
// decisions for that header: accept, abort (+abort_tag = tag being discarded),
// som (starts a message), eom (ends a message).
// Build option: MCTP_SINK_SEQ_CHECK_EN enables seq/tag/MAX_FRAGS checking.
module mctp_frag_tracker #(
    parameter int MAX_FRAGS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hdr_hs,
    input  logic [1:0] frag_type,
    input  logic [1:0] frag_seq,
    input  logic [3:0] frag_tag,
    output logic       accept,
    output logic       abort,
    output logic [3:0] abort_tag,
    output logic       som,
    output logic       eom
);
    import mctp_sink_pkg::*;

    asm_state_t state, state_n;
    logic [3:0] cur_tag, cur_tag_n;

`ifdef MCTP_SINK_SEQ_CHECK_EN
    localparam int CW = $clog2(MAX_FRAGS + 1);
    logic [1:0]    exp_seq, exp_seq_n;
    logic [CW-1:0] frag_cnt, frag_cnt_n;
`else
    logic unused_seq;
    assign unused_seq = ^{frag_seq, 1'(MAX_FRAGS)};
`endif

    always_comb begin
        accept    = 1'b0;
        abort     = 1'b0;
        abort_tag = cur_tag;
        state_n   = state;
        cur_tag_n = cur_tag;
`ifdef MCTP_SINK_SEQ_CHECK_EN
        exp_seq_n  = exp_seq;
        frag_cnt_n = frag_cnt;
`endif
        som = (frag_type == FRAG_S) || (frag_type == FRAG_SG);
        eom = (frag_type == FRAG_L) || (frag_type == FRAG_SG);
        case (frag_type)
            FRAG_SG: begin
                accept  = 1'b1;
                abort   = (state == A_ASM);
                state_n = A_IDLE;
            end
            FRAG_S: begin
                accept    = 1'b1;
                abort     = (state == A_ASM);
                state_n   = A_ASM;
                cur_tag_n = frag_tag;
`ifdef MCTP_SINK_SEQ_CHECK_EN
                exp_seq_n  = frag_seq + 2'd1;
                frag_cnt_n = CW'(1);
`endif
            end
            default: begin
                // M or L: only meaningful inside a message being assembled
                if (state == A_ASM) begin
`ifdef MCTP_SINK_SEQ_CHECK_EN
                    if (frag_tag != cur_tag || frag_seq != exp_seq ||
                        frag_cnt >= CW'(MAX_FRAGS)) begin
                        abort   = 1'b1;
                        state_n = A_IDLE;
                    end else begin
                        accept     = 1'b1;
                        exp_seq_n  = exp_seq + 2'd1;
                        frag_cnt_n = frag_cnt + CW'(1);
                        if (frag_type == FRAG_L) state_n = A_IDLE;
                    end
`else
                    accept = 1'b1;
                    if (frag_type == FRAG_L) state_n = A_IDLE;
`endif
                end
            end
        endcase
    end

    // L/SG return to idle at their header; no further header can arrive
    // before the burst ends, so this is equivalent to leaving at WLAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= A_IDLE;
            cur_tag <= 4'd0;
`ifdef MCTP_SINK_SEQ_CHECK_EN
            exp_seq  <= 2'd0;
            frag_cnt <= '0;
`endif
        end else if (hdr_hs) begin
            state   <= state_n;
            cur_tag <= cur_tag_n;
`ifdef MCTP_SINK_SEQ_CHECK_EN
            exp_seq  <= exp_seq_n;
            frag_cnt <= frag_cnt_n;
`endif
        end
    end

endmodule

// File: rtl/axi_mctp_write_sink.sv
// rtl/axi_mctp_write_sink.sv - AXI4 256b write slave terminating MCTP-over-VDM fragments
// Ports: i_clk/i_reset (async active-high); AXI AW (I_AW*/O_AWREADY), W (I_W*/O_WREADY),
// B (O_B*/I_BREADY); payload stream O_PLD_* with I_PLD_READY; O_HDR current
// fragment header; O_MSG_DONE/O_MSG_ABORT pulses with O_MSG_TAG.
// Build option: MCTP_SINK_SEQ_CHECK_EN (seq/tag/MAX_FRAGS checking in mctp_frag_tracker).
module axi_mctp_write_sink #(
    parameter int ID_W      = 7,
    parameter int MAX_FRAGS = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [ID_W-1:0] I_AWID,
    input  logic [63:0]     I_AWADDR,
    input  logic [7:0]      I_AWLEN,
    input  logic [2:0]      I_AWSIZE,
    input  logic [1:0]      I_AWBURST,
    input  logic            I_AWVALID,
    output logic            O_AWREADY,
    input  logic [255:0]    I_WDATA,
    input  logic [31:0]     I_WSTRB,
    input  logic            I_WLAST,
    input  logic            I_WVALID,
    output logic            O_WREADY,
    output logic [ID_W-1:0] O_BID,
    output logic [1:0]      O_BRESP,
    output logic            O_BVALID,
    input  logic            I_BREADY,
    output logic            O_PLD_VALID,
    output logic [255:0]    O_PLD_DATA,
    output logic            O_PLD_HALF,
    output logic            O_PLD_SOM,
    output logic            O_PLD_EOM,
    input  logic            I_PLD_READY,
    output logic [127:0]    O_HDR,
    output logic            O_MSG_DONE,
    output logic            O_MSG_ABORT,
    output logic [3:0]      O_MSG_TAG
);
    import mctp_sink_pkg::*;

    bus_state_t      bstate, bstate_n;
    logic [ID_W-1:0] bid_q;
    logic [7:0]      len_q, beat_cnt;
    logic [63:0]     awaddr_q;
    logic [1:0]      bresp_q;
    logic [127:0]    hdr_q;
    logic            cfg_err, ovf_err, drop_q, eom_q;
    logic            abort_q, done_q, done_hold;
    logic [3:0]      abort_tag_q, done_tag_q;

    logic beat0, drop, w_hs, hdr_hs, last_hs, eom_now, resp_err, done_set, abort_set;
    logic frag_accept, frag_abort, frag_som, frag_eom;
    logic [3:0] frag_abort_tag;

    logic unused_inputs;
    assign unused_inputs = ^{I_WSTRB, awaddr_q};

    mctp_frag_tracker #(.MAX_FRAGS(MAX_FRAGS)) u_tracker (
        .clk       (i_clk),
        .rst       (i_reset),
        .hdr_hs    (hdr_hs),
        .frag_type (I_WDATA[HDR_TYPE_MSB:HDR_TYPE_LSB]),
        .frag_seq  (I_WDATA[HDR_SEQ_MSB:HDR_SEQ_LSB]),
        .frag_tag  (I_WDATA[HDR_TAG_MSB:HDR_TAG_LSB]),
        .accept    (frag_accept),
        .abort     (frag_abort),
        .abort_tag (frag_abort_tag),
        .som       (frag_som),
        .eom       (frag_eom)
    );

    // Beat 0 decides from live WDATA; later beats reuse the latched decision.
    assign beat0     = (beat_cnt == 8'd0);
    assign drop      = beat0 ? !frag_accept : drop_q;
    assign eom_now   = beat0 ? frag_eom : eom_q;
    assign O_WREADY  = (bstate == B_DATA) && (drop || I_PLD_READY);
    assign w_hs      = (bstate == B_DATA) && I_WVALID && O_WREADY;
    assign hdr_hs    = w_hs && beat0;
    assign last_hs   = w_hs && I_WLAST;
    assign abort_set = hdr_hs && frag_abort;
    assign done_set  = last_hs && !drop && eom_now;
    assign resp_err  = cfg_err || ovf_err || (beat_cnt != len_q) || drop;

    assign O_AWREADY   = (bstate == B_IDLE);
    assign O_BVALID    = (bstate == B_RESP);
    assign O_BID       = bid_q;
    assign O_BRESP     = bresp_q;
    assign O_PLD_VALID = (bstate == B_DATA) && !drop && I_WVALID;
    assign O_PLD_DATA  = O_PLD_VALID ? {I_WDATA[255:128], beat0 ? 128'd0 : I_WDATA[127:0]} : 256'd0;
    assign O_PLD_HALF  = O_PLD_VALID && beat0;
    assign O_PLD_SOM   = O_PLD_VALID && beat0 && frag_som;
    assign O_PLD_EOM   = O_PLD_VALID && I_WLAST && eom_now;
    assign O_HDR       = hdr_q;
    assign O_MSG_DONE  = done_q;
    assign O_MSG_ABORT = abort_q;
    assign O_MSG_TAG   = abort_q ? abort_tag_q : (done_q ? done_tag_q : 4'd0);

    always_comb begin
        bstate_n = bstate;
        case (bstate)
            B_IDLE:  if (I_AWVALID) bstate_n = B_DATA;
            B_DATA:  if (last_hs)   bstate_n = B_RESP;
            B_RESP:  if (I_BREADY)  bstate_n = B_IDLE;
            default: bstate_n = B_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bstate      <= B_IDLE;
            bid_q       <= '0;
            len_q       <= 8'd0;
            beat_cnt    <= 8'd0;
            awaddr_q    <= 64'd0;
            bresp_q     <= BRESP_OKAY;
            hdr_q       <= 128'd0;
            cfg_err     <= 1'b0;
            ovf_err     <= 1'b0;
            drop_q      <= 1'b0;
            eom_q       <= 1'b0;
            abort_q     <= 1'b0;
            done_q      <= 1'b0;
            done_hold   <= 1'b0;
            abort_tag_q <= 4'd0;
            done_tag_q  <= 4'd0;
        end else begin
            bstate  <= bstate_n;
            abort_q <= abort_set;
            // A one-beat SG that also aborts: ABORT owns the tag first, DONE follows.
            done_q    <= (done_set && !abort_set) || done_hold;
            done_hold <= done_set && abort_set;
            if (abort_set) abort_tag_q <= frag_abort_tag;
            if (done_set)
                done_tag_q <= beat0 ? I_WDATA[HDR_TAG_MSB:HDR_TAG_LSB] : hdr_q[HDR_TAG_MSB-:4];
            if (bstate == B_IDLE && I_AWVALID) begin
                bid_q    <= I_AWID;
                len_q    <= I_AWLEN;
                awaddr_q <= I_AWADDR;
                cfg_err  <= (I_AWSIZE != AWSIZE_32B) || (I_AWBURST != AWBURST_INCR);
                beat_cnt <= 8'd0;
                ovf_err  <= 1'b0;
            end
            if (w_hs) begin
                // Saturating count; a beat past 256 can no longer match AWLEN+1.
                if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
                else if (!I_WLAST)     ovf_err  <= 1'b1;
            end
            if (hdr_hs) begin
                hdr_q  <= I_WDATA[127:0];
                drop_q <= !frag_accept;
                eom_q  <= frag_eom;
            end
            if (last_hs) bresp_q <= resp_err ? BRESP_SLVERR : BRESP_OKAY;
        end
    end

endmodule

// File: tb/tb_axi_mctp_write_sink.sv
// tb/tb_axi_mctp_write_sink.sv - scoreboard bench for axi_mctp_write_sink
module tb_axi_mctp_write_sink;

    localparam logic [1:0] FS = 2'b10, FM = 2'b00, FL = 2'b01, FG = 2'b11;
    localparam logic [1:0] OK = 2'b00, SE = 2'b10;

    logic clk = 1'b0;
    logic rst;
    logic [6:0]   I_AWID;
    logic [63:0]  I_AWADDR;
    logic [7:0]   I_AWLEN;
    logic [2:0]   I_AWSIZE;
    logic [1:0]   I_AWBURST;
    logic         I_AWVALID, I_WLAST, I_WVALID, I_BREADY, I_PLD_READY;
    logic [255:0] I_WDATA;
    logic [31:0]  I_WSTRB;
    logic         O_AWREADY, O_WREADY, O_BVALID, O_PLD_VALID, O_PLD_HALF, O_PLD_SOM, O_PLD_EOM;
    logic [6:0]   O_BID;
    logic [1:0]   O_BRESP;
    logic [255:0] O_PLD_DATA;
    logic [127:0] O_HDR;
    logic         O_MSG_DONE, O_MSG_ABORT;
    logic [3:0]   O_MSG_TAG;

    axi_mctp_write_sink #(.ID_W(7), .MAX_FRAGS(16)) dut (
        .i_clk(clk), .i_reset(rst),
        .I_AWID(I_AWID), .I_AWADDR(I_AWADDR), .I_AWLEN(I_AWLEN), .I_AWSIZE(I_AWSIZE),
        .I_AWBURST(I_AWBURST), .I_AWVALID(I_AWVALID), .O_AWREADY(O_AWREADY),
        .I_WDATA(I_WDATA), .I_WSTRB(I_WSTRB), .I_WLAST(I_WLAST), .I_WVALID(I_WVALID),
        .O_WREADY(O_WREADY), .O_BID(O_BID), .O_BRESP(O_BRESP), .O_BVALID(O_BVALID),
        .I_BREADY(I_BREADY), .O_PLD_VALID(O_PLD_VALID), .O_PLD_DATA(O_PLD_DATA),
        .O_PLD_HALF(O_PLD_HALF), .O_PLD_SOM(O_PLD_SOM), .O_PLD_EOM(O_PLD_EOM),
        .I_PLD_READY(I_PLD_READY), .O_HDR(O_HDR), .O_MSG_DONE(O_MSG_DONE),
        .O_MSG_ABORT(O_MSG_ABORT), .O_MSG_TAG(O_MSG_TAG)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [255:0] data;
        logic         half;
        logic         som;
        logic         eom;
    } pld_t;

    int checks = 0;
    int errors = 0;
    logic [8:0] b_q[$];
    pld_t       pld_q[$];
    logic [4:0] evt_q[$];
    bit tog_en = 1'b0;
    bit rdy_base = 1'b1;

    task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=handshake", name);
    endtask

    task automatic check_reset();
        chk("reset_ctrl", {O_AWREADY, O_WREADY, O_BVALID, O_BID, O_BRESP, O_PLD_VALID, O_PLD_HALF,
                           O_PLD_SOM, O_PLD_EOM, O_MSG_DONE, O_MSG_ABORT, O_MSG_TAG}, {1'b1, 21'h0});
        chk("reset_pld_data", O_PLD_DATA, 256'h0);
        chk("reset_hdr", O_HDR, 128'h0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a transfer or pulse.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (O_BVALID && I_BREADY) begin
                if (b_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bresp_unexpected actual=%0h expected=none", {O_BID, O_BRESP});
                end else chk("bid_bresp", {O_BID, O_BRESP}, b_q.pop_front());
            end
            if (O_PLD_VALID && I_PLD_READY) begin
                if (pld_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pld_unexpected actual=%0h expected=none", {O_PLD_HALF, O_PLD_SOM, O_PLD_EOM});
                end else chk("pld_beat", {O_PLD_DATA, O_PLD_HALF, O_PLD_SOM, O_PLD_EOM}, pld_q.pop_front());
            end
            if (O_MSG_DONE && O_MSG_ABORT) begin
                checks++; errors++;
                $display("FAIL pulse_overlap actual=both expected=one");
            end else if (O_MSG_DONE || O_MSG_ABORT) begin
                if (evt_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL msg_pulse_unexpected actual=%0h expected=none", {O_MSG_ABORT, O_MSG_TAG});
                end else chk("msg_pulse", {O_MSG_ABORT, O_MSG_TAG}, evt_q.pop_front());
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        I_PLD_READY = tog_en ? ~I_PLD_READY : rdy_base;
    end

    task automatic aw_send(input logic [6:0] id, input logic [2:0] size, input logic [1:0] bst,
                           input logic [7:0] len);
        int n;
        @(posedge clk); #1;
        I_AWID = id; I_AWADDR = {32'hF000_0000, 25'h0, id}; I_AWLEN = len;
        I_AWSIZE = size; I_AWBURST = bst; I_AWVALID = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (O_AWREADY) break;
            n++;
            if (n > 50) begin tmo("aw"); break; end
        end
        @(posedge clk); #1;
        I_AWVALID = 1'b0;
    endtask

    task automatic burst(input logic [6:0] id, input logic [2:0] size, input logic [1:0] bst,
                         input logic [7:0] len, input int nbeats, input logic [1:0] ft,
                         input logic [1:0] seq, input logic [3:0] tag, input bit acc,
                         input bit som, input bit eom, input logic [1:0] resp);
        logic [255:0] d;
        pld_t e;
        logic rdy;
        int n;
        b_q.push_back({id, resp});
        aw_send(id, size, bst, len);
        for (int b = 0; b < nbeats; b++) begin
            for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
            if (b == 0) d[127:120] = {ft, seq, tag};
            if (acc) begin
                e.data = (b == 0) ? {d[255:128], 128'h0} : d;
                e.half = (b == 0);
                e.som  = som && (b == 0);
                e.eom  = eom && (b == nbeats - 1);
                pld_q.push_back(e);
            end
            I_WDATA = d; I_WLAST = (b == nbeats - 1); I_WVALID = 1'b1;
            n = 0;
            do begin
                @(negedge clk); rdy = O_WREADY;
                @(posedge clk); #1;
                n++;
            end while (!rdy && n < 100);
            if (!rdy) tmo("w_beat");
        end
        I_WVALID = 1'b0; I_WLAST = 1'b0;
        n = 0;
        while (b_q.size() != 0 && n < 60) begin @(posedge clk); n++; end
        if (b_q.size() != 0) begin tmo("bresp"); b_q.delete(); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        I_AWID = '0; I_AWADDR = '0; I_AWLEN = '0; I_AWSIZE = '0; I_AWBURST = '0; I_AWVALID = 1'b0;
        I_WDATA = '0; I_WSTRB = '1; I_WLAST = 1'b0; I_WVALID = 1'b0; I_BREADY = 1'b1; I_PLD_READY = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // S + L, 4 beats each
        burst(7'h11, 3'd5, 2'b01, 8'd3, 4, FS, 2'd0, 4'h8, 1, 1, 0, OK);
        chk("hdr_byte", O_HDR[127:120], 8'h88);
        evt_q.push_back({1'b0, 4'h8});
        burst(7'h12, 3'd5, 2'b01, 8'd3, 4, FL, 2'd1, 4'h8, 1, 0, 1, OK);

        // S/M/M/L with payload backpressure toggling
        tog_en = 1'b1;
        burst(7'h20, 3'd5, 2'b01, 8'd1, 2, FS, 2'd0, 4'hA, 1, 1, 0, OK);
        burst(7'h21, 3'd5, 2'b01, 8'd1, 2, FM, 2'd1, 4'hA, 1, 0, 0, OK);
        burst(7'h22, 3'd5, 2'b01, 8'd1, 2, FM, 2'd2, 4'hA, 1, 0, 0, OK);
        evt_q.push_back({1'b0, 4'hA});
        burst(7'h23, 3'd5, 2'b01, 8'd1, 2, FL, 2'd3, 4'hA, 1, 0, 1, OK);
        tog_en = 1'b0;

        // sequence gap
        burst(7'h30, 3'd5, 2'b01, 8'd1, 2, FS, 2'd0, 4'h9, 1, 1, 0, OK);
`ifdef MCTP_SINK_SEQ_CHECK_EN
        evt_q.push_back({1'b1, 4'h9});
        burst(7'h31, 3'd5, 2'b01, 8'd1, 2, FM, 2'd2, 4'h9, 0, 0, 0, SE);
        burst(7'h32, 3'd5, 2'b01, 8'd1, 2, FL, 2'd3, 4'h9, 0, 0, 0, SE);
`else
        burst(7'h31, 3'd5, 2'b01, 8'd1, 2, FM, 2'd2, 4'h9, 1, 0, 0, OK);
        evt_q.push_back({1'b0, 4'h9});
        burst(7'h32, 3'd5, 2'b01, 8'd1, 2, FL, 2'd3, 4'h9, 1, 0, 1, OK);
`endif

        // SG single beat interrupting an in-progress message
        burst(7'h40, 3'd5, 2'b01, 8'd1, 2, FS, 2'd0, 4'h8, 1, 1, 0, OK);
        evt_q.push_back({1'b1, 4'h8});
        evt_q.push_back({1'b0, 4'hB});
        burst(7'h41, 3'd5, 2'b01, 8'd0, 1, FG, 2'd0, 4'hB, 1, 1, 1, OK);

        // AW attribute and beat count errors
        evt_q.push_back({1'b0, 4'hC});
        burst(7'h55, 3'd4, 2'b01, 8'd0, 1, FG, 2'd0, 4'hC, 1, 1, 1, SE);
        evt_q.push_back({1'b0, 4'hD});
        burst(7'h56, 3'd5, 2'b01, 8'd3, 3, FG, 2'd0, 4'hD, 1, 1, 1, SE);
        evt_q.push_back({1'b0, 4'hE});
        burst(7'h57, 3'd5, 2'b10, 8'd0, 1, FG, 2'd0, 4'hE, 1, 1, 1, SE);

        // MAX_FRAGS boundary: S + 15 M fills 16 fragments
        burst(7'h60, 3'd5, 2'b01, 8'd0, 1, FS, 2'd0, 4'h3, 1, 1, 0, OK);
        for (int i = 1; i < 16; i++)
            burst(7'h60, 3'd5, 2'b01, 8'd0, 1, FM, 2'(i), 4'h3, 1, 0, 0, OK);
`ifdef MCTP_SINK_SEQ_CHECK_EN
        evt_q.push_back({1'b1, 4'h3});
        burst(7'h61, 3'd5, 2'b01, 8'd0, 1, FM, 2'd0, 4'h3, 0, 0, 0, SE);
        burst(7'h62, 3'd5, 2'b01, 8'd0, 1, FL, 2'd1, 4'h3, 0, 0, 0, SE);
`else
        burst(7'h61, 3'd5, 2'b01, 8'd0, 1, FM, 2'd0, 4'h3, 1, 0, 0, OK);
        evt_q.push_back({1'b0, 4'h3});
        burst(7'h62, 3'd5, 2'b01, 8'd0, 1, FL, 2'd1, 4'h3, 1, 0, 1, OK);
`endif

        // reset in the middle of a stalled M burst
        burst(7'h70, 3'd5, 2'b01, 8'd0, 1, FS, 2'd0, 4'h5, 1, 1, 0, OK);
        rdy_base = 1'b0;
        @(posedge clk); #1;
        aw_send(7'h71, 3'd5, 2'b01, 8'd3);
        I_WDATA = {128'h1234, FM, 2'd1, 4'h5, 120'h0};
        I_WVALID = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset();
        I_WVALID = 1'b0;
        rdy_base = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        burst(7'h72, 3'd5, 2'b01, 8'd0, 1, FL, 2'd1, 4'h5, 0, 0, 0, SE);

        repeat (5) @(posedge clk);
        chk("b_q_drained", 32'(b_q.size()), 32'd0);
        chk("pld_q_drained", 32'(pld_q.size()), 32'd0);
        chk("evt_q_drained", 32'(evt_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
